ps2_key_tx: RTL
===============

// Module: ps2_key_tx
// PURPOSE
//  Encodes 11-bit toggle-format key events {toggle,pressed,extended,code[7:0]} into PS/2 device-to-host
//  serial frames: E0 prefix if extended, F0 prefix if released, then the scan code.
//  Used for keyboard replay and loopback: it drives the emulated-keyboard side of the PS/2 link,
//  and a PS/2 receiver feeding the key decoder in emu can recover the same event word.
//  A small event FIFO absorbs bursts, and host inhibit (clock held low) is honoured.
// PARAMETERS
//  CLK_DIV     400  clk_sys cycles per tick; one PS/2 clock half-period = 1 tick (15 kHz at 12 MHz)
//  FIFO_DEPTH  4    queued key events, power of two, >=2
//  GAP_TICKS   4    idle ticks, with clk and data released, after every byte
// PORTS
//  clk_sys      in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  ps2_key      in   11  [10] toggles per event, [9] pressed, [8] extended, [7:0] scan code
//  ps2_clk_in   in   1   sampled PS/2 clock line; low while the line is released = host inhibit
//  ps2_clk_out  out  1   open-drain clock drive: 1 = release, 0 = pull low
//  ps2_dat_out  out  1   open-drain data drive: 1 = release, 0 = pull low
//  busy         out  1   FIFO non-empty or frame or gap in progress
//  overflow     out  1   one-cycle pulse when an event is dropped because the FIFO is full
// BEHAVIOUR
//  Reset: ps2_clk_out=1, ps2_dat_out=1, busy=0, overflow=0, FIFO empty, state IDLE, divider=0, armed=0.
//  Event capture:
//   - First clock after reset: sample prev=ps2_key[10], set armed; no event is generated.
//   - Afterwards, ps2_key[10]!=prev pushes {ps2_key[9:8],ps2_key[7:0]} (10 bits) the same cycle.
//   - Push while full: event dropped, overflow=1 for exactly that cycle, FIFO contents unchanged.
//   - Push and pop in the same cycle are both allowed when the FIFO is full.
//  Tick divider: free-running 0..CLK_DIV-1; tick=1 on the CLK_DIV-1 cycle; reset to 0 on entry to BIT.
//  Sequencer states: IDLE, LOAD, BIT, GAP, INHIBIT.
//   - IDLE: FIFO non-empty and ps2_clk_in=1 -> LOAD (pop); if ps2_clk_in=0 -> stay.
//   - LOAD: build a byte queue of 1-3 bytes: E0 if ext, F0 if !pressed, then code.
//     Build shift[10:0]={1,~^byte,byte,0}, sent LSB first as start, D0..D7, odd parity, stop.
//     bit_idx=0 -> BIT.
//   - BIT, two ticks per bit:
//     - phase A: dat_out=shift[bit_idx], clk_out=1.
//     - phase B: clk_out=0, dat_out held.
//     - After phase B: bit_idx++; after bit 10, release both lines -> GAP.
//   - GAP: GAP_TICKS ticks released.
//     - More bytes queued: ps2_clk_in=1 -> next byte, BIT; ps2_clk_in=0 -> INHIBIT.
//     - Queue empty -> IDLE.
//   - Inhibit mid-frame: checked only in phase A. ps2_clk_in=0 with bit_idx<=9 aborts the frame:
//     release both lines -> INHIBIT. bit_idx=10 (stop bit) completes normally.
//   - INHIBIT: lines released; wait for ps2_clk_in=1 for 2 consecutive ticks.
//     Then resend the current byte from bit 0 (prefixes already sent are not repeated).
//  Parity: odd over the 8 data bits plus the parity bit. Frame = 22 ticks; byte period = 22+GAP_TICKS ticks.
//  busy=1 from the push cycle until IDLE with an empty FIFO.
//  Events are emitted strictly in arrival order. Reset mid-frame: outputs released immediately, queue lost.
// TESTING (CLK_DIV=4, GAP_TICKS=4, ps2_clk_in=1 unless stated)
//  1. Toggle with pressed=1, ext=0, code=29 -> single frame, start..stop bits 0,1,0,0,1,0,1,0,0,0,1;
//     clk low 11 times; busy falls 4 ticks after stop.
//  2. Toggle with pressed=0, ext=1, code=75 -> bytes E0 (parity 0), F0 (parity 1), 75 (parity 0)
//     in order, 26 ticks apart.
//  3. Five toggles in consecutive cycles while idle, FIFO_DEPTH=4 -> first pops to LOAD,
//     FIFO reaches 4, fifth... all accepted.
//     Six toggles -> exactly one overflow pulse; 5 events transmitted in order.
//  4. Pull ps2_clk_in=0 at bit_idx=5 of code 1C -> lines released within 1 tick.
//     Release -> after 2 ticks, 1C retransmitted in full from the start bit.
//  5. ps2_clk_in=0 during stop-bit phase A -> frame completes, next byte held in INHIBIT until released.
//  6. Assert reset_n=0 mid-byte -> ps2_clk_out=ps2_dat_out=1, busy=0 asynchronously.
//     After release, a stale ps2_key[10] level produces no event.

Source files
------------

// File: rtl/ps2_key_tx_if.sv
// ps2_key_tx_if: key event word in, open-drain PS/2 clock/data drives and status out
interface ps2_key_tx_if;
  logic [10:0] ps2_key;
  logic ps2_clk_in;
  logic ps2_clk_out;
  logic ps2_dat_out;
  logic busy;
  logic overflow;
  modport master (output ps2_key, ps2_clk_in, input ps2_clk_out, ps2_dat_out, busy, overflow);
  modport slave (input ps2_key, ps2_clk_in, output ps2_clk_out, ps2_dat_out, busy, overflow);
endinterface

// File: rtl/ps2_key_tx.sv
// ps2_key_tx: queues toggle-format key events and sends them as PS/2 device-to-host frames
module ps2_key_tx #(
  parameter int CLK_DIV = 400,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_TICKS = 4
) (
  input logic clk_sys,
  input logic reset_n,
  ps2_key_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_TICKS + 1);
  typedef enum logic [2:0] {IDLE, LOAD, BIT, GAP, INHIBIT} state_t;
  state_t state;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic armed, prev, ovf;
  logic push, pop, accept, full;
  logic [DW-1:0] div;
  logic tick, enter;
  logic [3:0] bit_idx;
  logic phase, icnt, more, ext_p, rel_p, clk_o, dat_o;
  logic [GW-1:0] gcnt;
  logic [7:0] code, cur;
  logic [11:0] frame;
  logic [9:0] ev;
  assign push = armed && bus.ps2_key[10] != prev;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign pop = state == IDLE && cnt != '0 && bus.ps2_clk_in;
  assign accept = push && (!full || pop);
  assign ev = mem[rd_ptr];
  assign tick = div == DW'(CLK_DIV - 1);
  // Prefix flags are consumed one per completed byte, so cur always names the byte in flight
  assign cur = ext_p ? 8'hE0 : rel_p ? 8'hF0 : code;
  // Bit 11 is the released level driven after the stop bit
  assign frame = {2'b11, ~^cur, cur, 1'b0};
  assign enter = state == LOAD || (tick && bus.ps2_clk_in &&
                 ((state == GAP && gcnt == GW'(GAP_TICKS - 1) && more) || (state == INHIBIT && icnt)));
  assign bus.ps2_clk_out = clk_o;
  assign bus.ps2_dat_out = dat_o;
  assign bus.overflow = ovf;
  assign bus.busy = state != IDLE || cnt != '0;
  always_ff @(posedge clk_sys)
    if (accept) mem[wr_ptr] <= bus.ps2_key[9:0];
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      armed <= 1'b0;
      prev <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      armed <= 1'b1;
      prev <= bus.ps2_key[10];
      ovf <= push && !accept;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(accept) - (AW+1)'(pop);
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      div <= '0;
      bit_idx <= '0;
      phase <= 1'b0;
      gcnt <= '0;
      icnt <= 1'b0;
      more <= 1'b0;
      ext_p <= 1'b0;
      rel_p <= 1'b0;
      code <= '0;
      clk_o <= 1'b1;
      dat_o <= 1'b1;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      case (state)
        IDLE: if (pop) begin
          {rel_p, ext_p, code} <= {~ev[9], ev[8], ev[7:0]};
          state <= LOAD;
        end
        BIT: if (tick) begin
          if (!phase) begin
            if (!bus.ps2_clk_in && bit_idx != 4'd10) begin
              dat_o <= 1'b1;
              icnt <= 1'b0;
              state <= INHIBIT;
            end else begin
              phase <= 1'b1;
              clk_o <= 1'b0;
            end
          end else begin
            phase <= 1'b0;
            clk_o <= 1'b1;
            bit_idx <= bit_idx + 4'd1;
            dat_o <= frame[bit_idx + 4'd1];
            if (bit_idx == 4'd10) begin
              more <= ext_p || rel_p;
              if (ext_p) ext_p <= 1'b0;
              else rel_p <= 1'b0;
              gcnt <= '0;
              state <= GAP;
            end
          end
        end
        GAP: if (tick) begin
          gcnt <= gcnt + 1'b1;
          icnt <= 1'b0;
          if (gcnt == GW'(GAP_TICKS - 1)) state <= more ? INHIBIT : IDLE;
        end
        INHIBIT: icnt <= bus.ps2_clk_in && (icnt || tick);
        default: ;
      endcase
      if (enter) begin
        state <= BIT;
        div <= '0;
        bit_idx <= '0;
        phase <= 1'b0;
        dat_o <= 1'b0;
      end
    end
endmodule
